// File: rtl/fetch_steer_pkg.sv
// Shared definitions for the fetch steering block: instruction fields, opcodes, bubble word, FSM states.
package fetch_steer_pkg;

  localparam int OPC_HI = 23;
  localparam int OPC_LO = 19;
  localparam int RD_HI  = 18;
  localparam int RD_LO  = 14;
  localparam int RS1_HI = 13;
  localparam int RS1_LO = 9;
  localparam int RS2_HI = 8;
  localparam int RS2_LO = 4;
  localparam int TGT_HI = 7;
  localparam int TGT_LO = 0;

  // R-type class occupies opcodes 5'h01..5'h07 (top two bits zero, excluding NOP)
  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_LD   = 5'h08;
  localparam logic [4:0] OP_ST   = 5'h09;
  localparam logic [4:0] OP_BEQZ = 5'h0C;
  localparam logic [4:0] OP_JMP  = 5'h10;
  localparam logic [1:0] RTYPE_CLASS = 2'b00;

  localparam logic [23:0] NOP_INS = 24'h0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic is_rtype(input logic [4:0] op);
    return (op[4:3] == RTYPE_CLASS) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/fetch_steer_if.sv
// Fetch <-> decode steering bus. FETCH_STEER_PERF_EN adds the stall/flush cycle counters.
interface fetch_steer_if;
  logic [23:0] ins;
  logic [7:0]  current_addr;
  logic        ex_br_taken;
  logic [7:0]  ex_br_target;
  logic [7:0]  jmp_loc;
  logic        pc_mux_sel;
  logic        stall;
  logic        stall_pm;
  logic        flush;
  logic [23:0] id_ins;
  logic [7:0]  id_pc;
  logic        id_valid;
`ifdef FETCH_STEER_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_cycles;
`endif

  modport master (
    output ins, current_addr, ex_br_taken, ex_br_target,
    input  jmp_loc, pc_mux_sel, stall, stall_pm, flush, id_ins, id_pc, id_valid
`ifdef FETCH_STEER_PERF_EN
    , input stall_cycles, flush_cycles
`endif
  );

  modport slave (
    input  ins, current_addr, ex_br_taken, ex_br_target,
    output jmp_loc, pc_mux_sel, stall, stall_pm, flush, id_ins, id_pc, id_valid
`ifdef FETCH_STEER_PERF_EN
    , output stall_cycles, flush_cycles
`endif
  );
endinterface

// File: rtl/fetch_steer_load_use_detect.sv
// Load-use hazard between the LD held in ID and the instruction arriving from fetch.
module fetch_steer_load_use_detect
  import fetch_steer_pkg::*;
(
  input  logic [4:0] id_op,
  input  logic [4:0] id_rd,
  input  logic [4:0] ins_op,
  input  logic [4:0] ins_rs1,
  input  logic [4:0] ins_rs2,
  output logic       hazard
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = (id_rd == ins_rs1);
  // only R-type instructions actually read rs2
  assign rs2_hit = is_rtype(ins_op) && (id_rd == ins_rs2);
  assign hazard  = (id_op == OP_LD) && (id_rd != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/fetch_steer.sv
// Decode-side fetch steering: jumps, branch redirects, load-use stalls, IF/ID register.
// Optional FETCH_STEER_PERF_EN: saturating stall/flush cycle counters on the bus.
//
// state    | meaning
// ST_RUN   | normal flow, ID captures fetched word, jumps steered
// ST_STALL | remaining load-use bubble cycles, fetch held
// ST_FLUSH | one wrong-path word after a taken branch is discarded
module fetch_steer
  import fetch_steer_pkg::*;
#(
  parameter int          LOAD_USE_STALL = 1,
  parameter logic [23:0] NOP_WORD       = 24'h0
) (
  input logic         clk,
  input logic         reset,
  fetch_steer_if.slave bus
);
  localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALL - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        load_id;
  logic        hazard;
  logic        is_jmp;
  logic [7:0]  jmp_loc;
  logic        pc_mux_sel, stall, stall_pm, flush;
  logic [23:0] id_ins;
  logic [7:0]  id_pc;
  logic        id_valid;

  fetch_steer_load_use_detect u_load_use_detect (
    .id_op  (id_ins[OPC_HI:OPC_LO]),
    .id_rd  (id_ins[RD_HI:RD_LO]),
    .ins_op (bus.ins[OPC_HI:OPC_LO]),
    .ins_rs1(bus.ins[RS1_HI:RS1_LO]),
    .ins_rs2(bus.ins[RS2_HI:RS2_LO]),
    .hazard (hazard)
  );

  assign is_jmp = (bus.ins[OPC_HI:OPC_LO] == OP_JMP);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load_id    = 1'b0;
    jmp_loc    = 8'h00;
    pc_mux_sel = 1'b0;
    stall      = 1'b0;
    stall_pm   = 1'b0;
    flush      = 1'b0;
    if (reset) begin
      state_nxt = ST_RUN;
      cnt_nxt   = 3'd0;
    end else if (bus.ex_br_taken) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = bus.ex_br_target;
      flush      = 1'b1;
      cnt_nxt    = 3'd0;
      state_nxt  = ST_FLUSH;
    end else begin
      unique case (state)
        ST_RUN: begin
          // a JMP never reads registers, so it outranks the hazard check
          if (is_jmp) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = bus.ins[TGT_HI:TGT_LO];
            load_id    = 1'b1;
          end else if (hazard) begin
            stall     = 1'b1;
            stall_pm  = 1'b1;
            cnt_nxt   = STALL_INIT;
            state_nxt = (STALL_INIT != 3'd0) ? ST_STALL : ST_RUN;
          end else begin
            load_id = 1'b1;
          end
        end
        ST_STALL: begin
          stall     = 1'b1;
          stall_pm  = 1'b1;
          cnt_nxt   = cnt - 3'd1;
          state_nxt = (cnt == 3'd1) ? ST_RUN : ST_STALL;
        end
        ST_FLUSH: state_nxt = ST_RUN;
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      cnt      <= 3'd0;
      id_ins   <= NOP_WORD;
      id_pc    <= 8'h00;
      id_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_id) begin
        id_ins   <= bus.ins;
        id_pc    <= bus.current_addr - 8'd1;
        id_valid <= 1'b1;
      end else begin
        id_ins   <= NOP_WORD;
        id_valid <= 1'b0;
      end
    end
  end

  assign bus.jmp_loc    = jmp_loc;
  assign bus.pc_mux_sel = pc_mux_sel;
  assign bus.stall      = stall;
  assign bus.stall_pm   = stall_pm;
  assign bus.flush      = flush;
  assign bus.id_ins     = id_ins;
  assign bus.id_pc      = id_pc;
  assign bus.id_valid   = id_valid;

`ifdef FETCH_STEER_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_cycles = flush_cnt;
`endif
endmodule

// File: tb/tb_fetch_steer.sv
// Randomized + directed bench for fetch_steer against a cycle-level reference model.
// Define FETCH_STEER_PERF_EN to also check the performance counters (incl. saturation).
module tb_fetch_steer;
  import fetch_steer_pkg::*;

  localparam int LUS = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  fetch_steer_if bus ();

  fetch_steer #(.LOAD_USE_STALL(LUS), .NOP_WORD(24'h0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  bit          m_init = 0;
  logic [23:0] m_id_ins;
  logic        m_id_valid;
  logic [7:0]  m_id_pc;
  int          m_stall_left;
  bit          m_wrong_path;
  bit          m_last_stall;
  int          m_sc, m_fc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [7:0] tgt);
    logic [23:0] w;
    w = {op, rd, rs1, rs2, 4'h0};
    if (op == OP_JMP || op == OP_BEQZ) w[7:0] = tgt;
    return w;
  endfunction

  function automatic logic [23:0] rand_ins();
    logic [4:0] op;
    case ($urandom_range(0, 6))
      0: op = OP_NOP;
      1: op = OP_ADD;
      2: op = OP_SUB;
      3: op = OP_LD;
      4: op = OP_ST;
      5: op = OP_BEQZ;
      default: op = OP_JMP;
    endcase
    return mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 8'($urandom));
  endfunction

  // a consumer waits on an LD in ID that writes a non-zero register it reads
  function automatic bit tb_hazard(input logic [23:0] idw, input logic [23:0] w);
    logic [4:0] rd;
    rd = idw[18:14];
    if (idw[23:19] != OP_LD || rd == 5'd0) return 1'b0;
    if (w[13:9] == rd) return 1'b1;
    return (w[23:19] inside {OP_ADD, OP_SUB}) && (w[8:4] == rd);
  endfunction

  task automatic cycle(input logic rst, input logic [23:0] i, input logic [7:0] a,
                       input logic br, input logic [7:0] bt);
    logic [7:0] e_jl;
    logic e_sel, e_st, e_fl, ld;
    @(negedge clk);
    reset = rst;
    bus.ins = i;
    bus.current_addr = a;
    bus.ex_br_taken = br;
    bus.ex_br_target = bt;
    #1;
    e_jl = 8'h00; e_sel = 0; e_st = 0; e_fl = 0; ld = 0;
    if (rst) begin
    end else if (br) begin
      e_sel = 1; e_jl = bt; e_fl = 1;
    end else if (m_wrong_path) begin
    end else if (m_stall_left > 0) begin
      e_st = 1;
    end else if (i[23:19] == OP_JMP) begin
      e_sel = 1; e_jl = i[7:0]; ld = 1;
    end else if (tb_hazard(m_id_ins, i)) begin
      e_st = 1;
    end else begin
      ld = 1;
    end

    check_val("jmp_loc", bus.jmp_loc, e_jl);
    check_val("pc_mux_sel", bus.pc_mux_sel, e_sel);
    check_val("stall", bus.stall, e_st);
    check_val("stall_pm", bus.stall_pm, e_st);
    check_val("flush", bus.flush, e_fl);
    if (m_init) begin
      check_val("id_ins", bus.id_ins, m_id_ins);
      check_val("id_valid", bus.id_valid, m_id_valid);
      if (m_id_valid) check_val("id_pc", bus.id_pc, m_id_pc);
`ifdef FETCH_STEER_PERF_EN
      check_val("stall_cycles", bus.stall_cycles, m_sc);
      check_val("flush_cycles", bus.flush_cycles, m_fc);
`endif
    end

    if (rst) begin
      m_init = 1; m_id_ins = 24'h0; m_id_valid = 0; m_id_pc = 8'h00;
      m_stall_left = 0; m_wrong_path = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (br) begin
        m_stall_left = 0; m_wrong_path = 1;
      end else if (m_wrong_path) begin
        m_wrong_path = 0;
      end else if (m_stall_left > 0) begin
        m_stall_left--;
      end else if (e_st) begin
        m_stall_left = LUS - 1;
      end
      if (ld) begin
        m_id_ins = i; m_id_valid = 1; m_id_pc = a - 8'd1;
      end else begin
        m_id_ins = 24'h0; m_id_valid = 0;
      end
      if (e_st && m_sc < 16'hFFFF) m_sc++;
      if (e_fl && m_fc < 16'hFFFF) m_fc++;
    end
    m_last_stall = e_st;
  endtask

  initial begin
    logic [23:0] cur;
    int n_st;
    bus.ins = 24'h0; bus.current_addr = 8'h00;
    bus.ex_br_taken = 1'b0; bus.ex_br_target = 8'h00;

    for (int k = 0; k < 3; k++) cycle(1, rand_ins(), 8'($urandom), 1'($urandom), 8'($urandom));

    cycle(0, mk(OP_JMP, 5'd0, 5'd0, 5'd0, 8'h40), 8'h11, 0, 8'h00);
    cycle(0, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 8'h00), 8'h12, 0, 8'h00);

    // LD r3 then dependent ADD r5,r3,r1: count stall cycles explicitly
    cycle(0, mk(OP_LD, 5'd3, 5'd2, 5'd0, 8'h00), 8'h13, 0, 8'h00);
    n_st = 0;
    for (int k = 0; k < LUS + 1; k++) begin
      cycle(0, mk(OP_ADD, 5'd5, 5'd3, 5'd1, 8'h00), 8'h14, 0, 8'h00);
      if (bus.stall) n_st++;
    end
    check_val("stall_len", n_st, LUS);
    cycle(0, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 8'h00), 8'h15, 0, 8'h00);
    check_val("add_in_id", bus.id_ins, mk(OP_ADD, 5'd5, 5'd3, 5'd1, 8'h00));

    // LD r0 never stalls; rs2 match on a non-R-type never stalls
    cycle(0, mk(OP_LD, 5'd0, 5'd1, 5'd0, 8'h00), 8'h20, 0, 8'h00);
    cycle(0, mk(OP_ADD, 5'd5, 5'd0, 5'd0, 8'h00), 8'h21, 0, 8'h00);
    cycle(0, mk(OP_LD, 5'd2, 5'd1, 5'd0, 8'h00), 8'h22, 0, 8'h00);
    cycle(0, mk(OP_ST, 5'd1, 5'd1, 5'd2, 8'h00), 8'h23, 0, 8'h00);
    cycle(0, mk(OP_LD, 5'd2, 5'd1, 5'd0, 8'h00), 8'h24, 0, 8'h00);
    cycle(0, mk(OP_SUB, 5'd1, 5'd1, 5'd2, 8'h00), 8'h25, 0, 8'h00);
    for (int k = 0; k < LUS; k++) cycle(0, mk(OP_SUB, 5'd1, 5'd1, 5'd2, 8'h00), 8'h25, 0, 8'h00);

    // taken branch to 8'h20, then back-to-back branches
    cycle(0, mk(OP_ADD, 5'd1, 5'd1, 5'd1, 8'h00), 8'h30, 1, 8'h20);
    cycle(0, mk(OP_JMP, 5'd0, 5'd0, 5'd0, 8'h77), 8'h20, 0, 8'h00);
    cycle(0, mk(OP_ADD, 5'd4, 5'd4, 5'd4, 8'h00), 8'h21, 0, 8'h00);
    cycle(0, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 8'h00), 8'h22, 1, 8'h50);
    cycle(0, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 8'h00), 8'h50, 1, 8'h60);
    cycle(0, mk(OP_ADD, 5'd4, 5'd4, 5'd4, 8'h00), 8'h61, 0, 8'h00);

    // branch with simultaneous load-use and JMP
    cycle(0, mk(OP_LD, 5'd3, 5'd2, 5'd0, 8'h00), 8'h40, 0, 8'h00);
    cycle(0, mk(OP_JMP, 5'd0, 5'd3, 5'd0, 8'h99), 8'h41, 1, 8'hA0);
    cycle(0, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 8'h00), 8'hA0, 0, 8'h00);

    // branch during STALL, then reset during STALL
    cycle(0, mk(OP_LD, 5'd3, 5'd2, 5'd0, 8'h00), 8'h50, 0, 8'h00);
    cycle(0, mk(OP_ADD, 5'd5, 5'd3, 5'd1, 8'h00), 8'h51, 0, 8'h00);
    cycle(0, mk(OP_ADD, 5'd5, 5'd3, 5'd1, 8'h00), 8'h51, 1, 8'h70);
    cycle(0, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 8'h00), 8'h70, 0, 8'h00);
    cycle(0, mk(OP_LD, 5'd3, 5'd2, 5'd0, 8'h00), 8'h71, 0, 8'h00);
    cycle(0, mk(OP_ADD, 5'd5, 5'd3, 5'd1, 8'h00), 8'h72, 0, 8'h00);
    cycle(0, mk(OP_ADD, 5'd5, 5'd3, 5'd1, 8'h00), 8'h72, 0, 8'h00);
    cycle(1, mk(OP_ADD, 5'd5, 5'd3, 5'd1, 8'h00), 8'h72, 0, 8'h00);
    cycle(0, mk(OP_ADD, 5'd5, 5'd3, 5'd1, 8'h00), 8'h72, 0, 8'h00);
    cycle(0, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 8'h00), 8'h73, 0, 8'h00);

    // random traffic; fetch replays the word while stalled
    cur = rand_ins();
    for (int k = 0; k < 3000; k++) begin
      if (!m_last_stall) cur = rand_ins();
      cycle(($urandom_range(0, 99) == 0), cur, 8'($urandom),
            ($urandom_range(0, 9) == 0), 8'($urandom));
    end

`ifdef FETCH_STEER_PERF_EN
    cycle(1, 24'h0, 8'h00, 0, 8'h00);
    for (int k = 0; k < 65540; k++) cycle(0, rand_ins(), 8'($urandom), 1, 8'($urandom));
    check_val("flush_sat", bus.flush_cycles, 16'hFFFF);
    cycle(1, 24'h0, 8'h00, 0, 8'h00);
    cycle(0, 24'h0, 8'h01, 0, 8'h00);
    check_val("flush_clr", bus.flush_cycles, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
